// File: rtl/seq_tx_if.sv
// Payload handshake between an upstream word source and the sync-frame transmitter.
interface seq_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] DIN;
    logic             DIN_VALID;
    logic             DIN_READY;

    modport master (output DIN, output DIN_VALID, input DIN_READY);
    modport slave  (input DIN, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/seq_tx.sv
// Serial sync-frame transmitter: sends 1101, then the payload MSB-first, then a zero gap.
// Every output is registered and computed from the next state so X_OUT lines up with the frame.
module seq_tx #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned GAP_LEN = 2
) (
    input  logic     CLK,
    input  logic     nRESET,
    seq_tx_if.slave  up,
    output logic     X_OUT,
    output logic     BUSY,
    output logic     FRAME_DONE
);
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned GAP_W  = 4;
    localparam logic [3:0]  SYNC_PAT = 4'b1101;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [1:0]         sync_idx_q, sync_idx_d;
    logic               x_q, x_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    // State and output registers
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            sync_idx_q <= '0;
            x_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sync_idx_q <= sync_idx_d;
            x_q        <= x_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state and datapath sequencing
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sync_idx_d = sync_idx_q;
        case (state_q)
            IDLE: begin
                if (up.DIN_VALID) begin
                    state_d    = SYNC;
                    shift_d    = up.DIN;
                    sync_idx_d = 2'd0;
                end
            end
            SYNC: begin
                if (sync_idx_q == 2'd3) begin
                    state_d    = DATA;
                    bit_cnt_d  = CNT_W'(WIDTH);
                    sync_idx_d = 2'd0;
                end else begin
                    sync_idx_d = sync_idx_q + 2'd1;
                end
            end
            DATA: begin
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
                shift_d   = shift_q << 1;
                if (bit_cnt_q == CNT_W'(1)) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_W'(GAP_LEN);
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the cycle being entered
    always_comb begin
        x_d     = 1'b0;
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        done_d  = (state_q == GAP) && (state_d == IDLE);
        case (state_d)
            SYNC:    x_d = SYNC_PAT[2'd3 - sync_idx_d];
            DATA:    x_d = shift_d[WIDTH-1];
            default: x_d = 1'b0;
        endcase
    end

    assign X_OUT        = x_q;
    assign BUSY         = busy_q;
    assign FRAME_DONE   = done_q;
    assign up.DIN_READY = ready_q;

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: frame vector table, hand-written corner sequences, and random
// traffic checked every cycle against a queue-based model of the serial line.
module tb_seq_tx;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned GAP_LEN = 2;
    localparam int unsigned FLEN    = 4 + WIDTH + GAP_LEN;

    logic CLK    = 1'b0;
    logic nRESET = 1'b1;
    logic X_OUT, BUSY, FRAME_DONE;

    int errors = 0;
    int checks = 0;

    seq_tx_if #(.WIDTH(WIDTH)) bus ();

    seq_tx #(.WIDTH(WIDTH), .GAP_LEN(GAP_LEN)) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .up         (bus),
        .X_OUT      (X_OUT),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the line carries a queue of pending frame bits
    typedef bit bitq_t[$];

    function automatic bitq_t frame_bits(input logic [WIDTH-1:0] d);
        bitq_t q;
        q = {};
        q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
        for (int i = int'(WIDTH) - 1; i >= 0; i--) q.push_back(d[i]);
        for (int i = 0; i < int'(GAP_LEN); i++) q.push_back(1'b0);
        return q;
    endfunction

    bitq_t mq;
    bit    m_done;

    initial begin
        forever begin
            @(posedge CLK);
            m_done = 1'b0;
            if (!nRESET) begin
                mq.delete();
            end else if (mq.size() == 0) begin
                if (bus.DIN_VALID) mq = frame_bits(bus.DIN);
            end else begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1'b1;
            end
            #1;
            if (mq.size() != 0)
                check("model", 32'({X_OUT, BUSY, bus.DIN_READY, FRAME_DONE}),
                      32'({mq[0], 1'b1, 1'b0, m_done}));
            else
                check("model", 32'({X_OUT, BUSY, bus.DIN_READY, FRAME_DONE}),
                      32'({1'b0, 1'b0, 1'b1, m_done}));
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge CLK);
        while (!bus.DIN_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("wait_ready", 32'(bus.DIN_READY), 32'(1));
    endtask

    // Sends one frame and records the line; inject pulses a foreign word during SYNC
    task automatic run_frame(input logic [WIDTH-1:0] din, input bit inject,
                             output logic [FLEN-1:0] bits, output logic [FLEN-1:0] zmask,
                             output logic quiet, output logic done_ok);
        logic [3:0] hist;
        hist = '0; bits = '0; zmask = '0; quiet = 1'b1;
        wait_ready();
        bus.DIN = din;
        bus.DIN_VALID = 1'b1;
        @(posedge CLK);
        for (int k = 0; k < int'(FLEN); k++) begin
            @(negedge CLK);
            if (k == 0) bus.DIN_VALID = 1'b0;
            if (inject && k == 1) begin bus.DIN = 8'hFF; bus.DIN_VALID = 1'b1; end
            if (inject && k == 2) bus.DIN_VALID = 1'b0;
            bits[int'(FLEN) - 1 - k] = X_OUT;
            hist = {hist[2:0], X_OUT};
            if (hist == 4'b1101) zmask[int'(FLEN) - 1 - k] = 1'b1;
            if (bus.DIN_READY || FRAME_DONE) quiet = 1'b0;
        end
        @(negedge CLK);
        done_ok = FRAME_DONE && bus.DIN_READY;
    endtask

    typedef struct {
        logic [WIDTH-1:0] din;
        logic [FLEN-1:0]  bits;
        logic [FLEN-1:0]  zmask;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [FLEN-1:0] bits, zmask;
        logic            quiet, done_ok;
        logic [29:0]     cap;
        int              dones;

        vecs[0] = '{8'h0F, 14'b11010000111100, 14'b00010000000000};
        vecs[1] = '{8'hA5, 14'b11011010010100, 14'b00010010000000};
        vecs[2] = '{8'hFF, 14'b11011111111100, 14'b00010000000000};
        vecs[3] = '{8'h6D, 14'b11010110110100, 14'b00010000100100};
        vecs[4] = '{8'h00, 14'b11010000000000, 14'b00010000000000};
        vecs[5] = '{8'h01, 14'b11010000000100, 14'b00010000000000};

        bus.DIN = '0;
        bus.DIN_VALID = 1'b0;
        #1 nRESET = 1'b0;
        #2;
        check("reset_x",     32'(X_OUT),         32'(0));
        check("reset_busy",  32'(BUSY),          32'(0));
        check("reset_done",  32'(FRAME_DONE),    32'(0));
        check("reset_ready", 32'(bus.DIN_READY), 32'(1));
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        nRESET = 1'b1;

        // Frame table, including loopback detection positions
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].din, 1'b0, bits, zmask, quiet, done_ok);
            check($sformatf("frame_bits_%0h", vecs[i].din), 32'(bits), 32'(vecs[i].bits));
            check($sformatf("frame_z_%0h", vecs[i].din), 32'(zmask), 32'(vecs[i].zmask));
            check($sformatf("frame_quiet_%0h", vecs[i].din), 32'(quiet), 32'(1));
            check($sformatf("frame_done_%0h", vecs[i].din), 32'(done_ok), 32'(1));
        end

        // Busy ignore: word offered during SYNC must not disturb the frame
        run_frame(8'h0F, 1'b1, bits, zmask, quiet, done_ok);
        check("busy_bits",  32'(bits),    32'(14'b11010000111100));
        check("busy_ready", 32'(quiet),   32'(1));
        check("busy_done",  32'(done_ok), 32'(1));

        // Back-to-back frames with DIN_VALID held high
        wait_ready();
        bus.DIN = 8'h0F;
        bus.DIN_VALID = 1'b1;
        @(posedge CLK);
        cap = '0;
        dones = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge CLK);
            if (k == 1) bus.DIN = 8'h33;
            if (k == 16) bus.DIN_VALID = 1'b0;
            cap[30 - k] = X_OUT;
            if (FRAME_DONE) dones++;
        end
        check("b2b_line", 32'(cap), 32'({14'b11010000111100, 1'b0, 14'b11010011001100, 1'b0}));
        check("b2b_sync_at_16", 32'(cap[14]), 32'(1));
        check("b2b_done_count", 32'(dones), 32'(2));

        // Reset mid-DATA aborts the frame with no completion pulse
        wait_ready();
        bus.DIN = 8'hFF;
        bus.DIN_VALID = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 1) bus.DIN_VALID = 1'b0;
        end
        check("pre_reset_x", 32'(X_OUT), 32'(1));
        nRESET = 1'b0;
        #1;
        check("abort_x",    32'(X_OUT),      32'(0));
        check("abort_busy", 32'(BUSY),       32'(0));
        check("abort_done", 32'(FRAME_DONE), 32'(0));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRESET = 1'b1;
        #1;
        check("release_ready", 32'(bus.DIN_READY), 32'(1));
        check("release_busy",  32'(BUSY),          32'(0));
        dones = 0;
        repeat (20) begin
            @(negedge CLK);
            if (FRAME_DONE) dones++;
        end
        check("abort_no_done", 32'(dones), 32'(0));

        // Random traffic checked by the per-cycle model
        repeat (400) begin
            @(negedge CLK);
            bus.DIN_VALID = ($urandom_range(0, 2) != 0);
            bus.DIN = WIDTH'($urandom);
        end
        @(negedge CLK);
        bus.DIN_VALID = 1'b0;
        repeat (30) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
